// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// header length and checksum width.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned SUM_W     = 8;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory byte write port of the boot loader.
// The loader takes the slave side; the stream source / memory model takes master.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_byte_sum.sv
// Running modulo-256 adder with synchronous clear and enable; accumulates
// payload bytes for the load checksum.
module boot_byte_sum
  import boot_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [SUM_W-1:0] data,
  output logic [SUM_W-1:0] sum
);

  logic [SUM_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + data;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory and
// releases the CPU from reset once the checksum matches.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned       MEM_BYTES = 1024,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus,
  output logic                cpu_rst,
  output logic                done,
  output logic                err
);

  state_e            state_q, state_d;
  logic [31:0]       len_q;
  logic [31:0]       len_full;
  logic [1:0]        hcnt_q;
  logic [31:0]       idx_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              accept;
  logic              sum_en;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_chk;

  assign accept   = bus.in_valid && bus.in_ready;
  // Header arrives LSB first, so shifting in from the top leaves byte 0 at 7:0.
  assign len_full = {bus.in_data, len_q[31:8]};
  assign sum_en   = accept && (state_q == ST_DATA);
  assign sum_chk  = sum + bus.in_data;

  boot_byte_sum u_sum (
    .clk  (clk),
    .clr  (rst),
    .en   (sum_en),
    .data (bus.in_data),
    .sum  (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HDR: begin
        if (accept && hcnt_q == 2'(HDR_BYTES - 1)) begin
          if (len_full > 32'(MEM_BYTES)) begin
            state_d = ST_ERR;
          end else if (len_full == 32'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept && idx_q == len_q - 32'd1) begin
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_d = (sum_chk == '0) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    bus.in_ready  = !rst && (state_q == ST_HDR || state_q == ST_DATA || state_q == ST_CSUM);
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    done          = (state_q == ST_DONE);
    err           = (state_q == ST_ERR);
    cpu_rst       = (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      hcnt_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        unique case (state_q)
          ST_HDR: begin
            len_q  <= len_full;
            hcnt_q <= hcnt_q + 2'd1;
          end
          ST_DATA: begin
            we_q    <= 1'b1;
            addr_q  <= BASE_ADDR + ADDR_W'(idx_q);
            wdata_q <= bus.in_data;
            idx_q   <= idx_q + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
